uart_rx_mv: RTL and testbench

- UART receive front end with a 2-flop input synchronizer and 3-sample majority vote at each mid-bit.
- Detects false starts and framing errors.
- Delivers each received byte as a one-cycle `rx_ready` pulse with `rx_data` held stable.
- Sits between the RX pin and the host command parser ("S", register hex digit, two data hex digits); drop-in producer for the parser's `rx_ready`/`rx_data` inputs.

---
 rtl/uart_rx_mv_if.sv | 25 ++
 rtl/uart_rx_mv.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_mv.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_mv_if.sv
// Serial line and received-byte bundle for uart_rx_mv.
// master: the receiver; slave: the consumer/line driver.
interface uart_rx_mv_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_busy;

    modport master (
        input  rx,
        output rx_ready,
        output rx_data,
        output rx_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_ready,
        input  rx_data,
        input  rx_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_mv.sv
// UART receiver: 2-flop sync, 3-sample mid-bit majority vote, 8N1.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity check.
module uart_rx_mv #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115200
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_mv_if.master bus
);
    localparam int CPB  = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
    } state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_q, data_n;
    logic          ready_q, ready_n;
    logic          err_q, err_n;
    logic          smp0, smp0_n;
    logic          smp1, smp1_n;
    logic          s1, s2, s3;
    logic          fall, maj, dec, last, good;

`ifdef UART_RX_PARITY_EN
    logic          perr, perr_n;
`endif

    assign fall = s3 & ~s2;
    assign dec  = (cnt == C_DEC);
    assign last = (cnt == C_LAST);
    // Third vote is taken live from s2 in the decision cycle
    assign maj  = (smp0 & smp1) | (smp0 & s2) | (smp1 & s2);

`ifdef UART_RX_PARITY_EN
    assign good = maj & ~perr;
`else
    assign good = maj;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_q;
        ready_n = 1'b0;
        err_n   = 1'b0;
        smp0_n  = smp0;
        smp1_n  = smp1;
`ifdef UART_RX_PARITY_EN
        perr_n  = perr;
`endif
        if (state != IDLE)
            cnt_n = last ? '0 : cnt + C_ONE;
        if (cnt == C_S0)
            smp0_n = s2;
        if (cnt == C_S1)
            smp1_n = s2;

        unique case (state)
            IDLE: begin
                // The edge cycle itself counts as cnt 0
                if (fall) begin
                    state_n = START;
                    cnt_n   = C_ONE;
`ifdef UART_RX_PARITY_EN
                    perr_n  = 1'b0;
`endif
                end
            end
            START: begin
                if (dec && maj) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (last) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (dec)
                    shift_n = {maj, shift[7:1]};
                if (last) begin
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (dec)
                    perr_n = (maj != ^shift);
                if (last)
                    state_n = STOP;
            end
`endif
            STOP: begin
                // Leave at mid-stop so a zero-gap start bit is caught
                if (dec) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    if (good) begin
                        data_n  = shift;
                        ready_n = 1'b1;
                    end else begin
                        err_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            s3      <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            smp0    <= 1'b1;
            smp1    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr    <= 1'b0;
`endif
        end else begin
            s1      <= bus.rx;
            s2      <= s1;
            s3      <= s2;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            data_q  <= data_n;
            ready_q <= ready_n;
            err_q   <= err_n;
            smp0    <= smp0_n;
            smp1    <= smp1_n;
`ifdef UART_RX_PARITY_EN
            perr    <= perr_n;
`endif
        end
    end

    assign bus.rx_ready = ready_q;
    assign bus.rx_err   = err_q;
    assign bus.rx_data  = data_q;
    assign bus.rx_busy  = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_mv.sv
// Self-checking bench for uart_rx_mv: table of frames plus corner
// sequences, results checked through an expected-result queue.
module tb_uart_rx_mv;
    localparam int CPB  = 104;
    localparam int HALF = 52;
`ifdef UART_RX_PARITY_EN
    localparam int NSLOT = 11;
    localparam int LAT   = 2 + 10 * CPB + HALF + 2;
`else
    localparam int NSLOT = 10;
    localparam int LAT   = 2 + 9 * CPB + HALF + 2;
`endif

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        bit         stp;
        int         gbit;
        bit         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   frame_c0 = 0;
    int   last_pulse_cyc = 0;
    bit   prev_pulse = 0;
    exp_t sb[$];

    uart_rx_mv_if bus ();

    uart_rx_mv #(
        .CLK_FREQ(12_000_000),
        .BAUD    (115200)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        bit   p;
        p = bus.rx_ready || bus.rx_err;
        if (p) begin
            checks++;
            last_pulse_cyc = cyc;
            if (bus.rx_ready && bus.rx_err) begin
                errors++;
                $display("FAIL both_pulses: ready=1 err=1, need one");
            end else if (prev_pulse) begin
                errors++;
                $display("FAIL pulse_width: pulse >1 cycle at %0d", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected: ready=%0b err=%0b data=%0h, none expected",
                         bus.rx_ready, bus.rx_err, bus.rx_data);
            end else begin
                e = sb.pop_front();
                if (bus.rx_err !== e.err || bus.rx_data !== e.data) begin
                    errors++;
                    $display("FAIL result: err=%0b data=%0h, expected err=%0b data=%0h",
                             bus.rx_err, bus.rx_data, e.err, e.data);
                end
            end
        end
        prev_pulse = p;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stp,
                              input int gbit, input bit pbad,
                              input int ncyc);
        logic sl [0:10];
        int   n;
        n = 0;
        sl[0] = 1'b0;
        for (int b = 0; b < 8; b++) sl[b+1] = d[b];
`ifdef UART_RX_PARITY_EN
        sl[9]  = ^d ^ pbad;
        sl[10] = stp;
`else
        sl[9]  = stp;
        sl[10] = ^d ^ pbad;
`endif
        frame_c0 = cyc;
        for (int s = 0; s < NSLOT; s++) begin
            for (int k = 0; k < CPB; k++) begin
                if (ncyc >= 0 && n >= ncyc) return;
                bus.rx = sl[s] ^ ((s == gbit + 1) && (k == HALF));
                n++;
                tick();
            end
        end
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        bus.rx = 1'b1;
        while (sb.size() != 0 && i < 4 * CPB) begin
            tick();
            i++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results outstanding, expected 0",
                     nm, sb.size());
            sb.delete();
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl [6];
        int   c0;
        exp_t e;

        tbl[0] = '{8'h41, 1'b0, -1, 1'b1, 8'h53};
        tbl[1] = '{8'hA5, 1'b1,  3, 1'b0, 8'hA5};
        tbl[2] = '{8'h00, 1'b1, -1, 1'b0, 8'h00};
        tbl[3] = '{8'h80, 1'b0, -1, 1'b1, 8'h00};
        tbl[4] = '{8'hFF, 1'b1,  5, 1'b0, 8'hFF};
        tbl[5] = '{8'h01, 1'b1, -1, 1'b0, 8'h01};

        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.rx_ready), 32'h0);
        chk("rst_err",   32'(bus.rx_err),   32'h0);
        chk("rst_busy",  32'(bus.rx_busy),  32'h0);
        chk("rst_data",  32'(bus.rx_data),  32'h0);
        rst_n = 1'b1;
        repeat (20) tick();

        e = '{1'b0, 8'h53};
        sb.push_back(e);
        send_frame(8'h53, 1'b1, -1, 1'b0, -1);
        drain("first_53");
        chk("latency", 32'(last_pulse_cyc - frame_c0), 32'(LAT));

        c0 = cyc;
        for (int i = 0; i < 80; i++) begin
            bus.rx = (i < 20) ? 1'b0 : 1'b1;
            tick();
            if (cyc == c0 + 2 + 53)
                chk("fs_busy_hi", 32'(bus.rx_busy), 32'h1);
            if (cyc == c0 + 2 + 54)
                chk("fs_busy_lo", 32'(bus.rx_busy), 32'h0);
        end
        repeat (CPB) tick();

        for (int i = 0; i < 6; i++) begin
            e = '{tbl[i].exp_err, tbl[i].exp_data};
            sb.push_back(e);
            send_frame(tbl[i].d, tbl[i].stp, tbl[i].gbit, 1'b0, -1);
            drain($sformatf("vec%0d", i));
        end

        send_frame(8'h31, 1'b1, -1, 1'b0, 5 * CPB + 30);
        chk("mid_busy", 32'(bus.rx_busy), 32'h1);
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        tick();
        rst_n  = 1'b1;
        chk("mrst_ready", 32'(bus.rx_ready), 32'h0);
        chk("mrst_err",   32'(bus.rx_err),   32'h0);
        chk("mrst_busy",  32'(bus.rx_busy),  32'h0);
        chk("mrst_data",  32'(bus.rx_data),  32'h0);
        repeat (12 * CPB) tick();
        e = '{1'b0, 8'h0A};
        sb.push_back(e);
        send_frame(8'h0A, 1'b1, -1, 1'b0, -1);
        drain("after_rst_0A");

        e = '{1'b0, 8'h53}; sb.push_back(e);
        e = '{1'b0, 8'h33}; sb.push_back(e);
        e = '{1'b0, 8'h46}; sb.push_back(e);
        e = '{1'b0, 8'h46}; sb.push_back(e);
        send_frame(8'h53, 1'b1, -1, 1'b0, -1);
        send_frame(8'h33, 1'b1, -1, 1'b0, -1);
        send_frame(8'h46, 1'b1, -1, 1'b0, -1);
        send_frame(8'h46, 1'b1, -1, 1'b0, -1);
        drain("b2b_S3FF");

        e = '{1'b1, 8'h46};
        sb.push_back(e);
        bus.rx = 1'b0;
        repeat (12 * CPB) tick();
        bus.rx = 1'b1;
        drain("break");

`ifdef UART_RX_PARITY_EN
        e = '{1'b0, 8'h53};
        sb.push_back(e);
        send_frame(8'h53, 1'b1, -1, 1'b0, -1);
        drain("par_good");
        e = '{1'b1, 8'h53};
        sb.push_back(e);
        send_frame(8'h46, 1'b1, -1, 1'b1, -1);
        drain("par_bad");
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
